db_arbiter: RTL and testbench
=============================

// Module: db_arbiter
// PURPOSE
//  Two-requester arbiter for the shared physical data bus (DataBus.vh protocol).
//  Requester 0 is the CPU_MMU bus side; requester 1 is a secondary master (DMA/debug).
//  Grants one requester at a time, holds the grant until the transfer completes,
//  aborts or times out, and rotates priority round-robin between the two.
//  Sits between the bus masters and the memory/IO decoder.
// PARAMETERS
//  TIMEOUT   64   cycles in BUSY without db_ready before forced error completion; 0 = disabled
//  CNT_W     8    timeout counter width; must satisfy 2**CNT_W > TIMEOUT
// PORTS
//  clk             in   1            system clock, all state on posedge
//  res             in   1            reset; asynchronous, active-high
//  mN_addr         in   32           requester N address (N = 0,1)
//  mN_dataOut      in   32           requester N write data
//  mN_accessType   in   `MEM_ACCESS  requester N request; != `MEM_ACCESS_NONE means request
//  mN_memLen       in   `MEM_LEN     requester N transfer length
//  mN_io           in   1            requester N IO-space flag
//  mN_lock         in   1            keep grant after this transfer completes
//  mN_dataIn       out  32           read data to requester N (= db_dataIn, unregistered)
//  mN_ready        out  1            one-cycle completion strobe to requester N
//  mN_err          out  1            qualifies mN_ready: transfer timed out
//  db_addr         out  32           downstream address
//  db_dataOut      out  32           downstream write data
//  db_accessType   out  `MEM_ACCESS  downstream access type
//  db_memLen       out  `MEM_LEN     downstream length
//  db_io           out  1            downstream IO flag
//  db_dataIn       in   32           downstream read data
//  db_ready        in   1            downstream completion
//  grant           out  1            current owner index (valid while busy)
//  busy            out  1            1 while in BUSY
// BEHAVIOUR
//  Reset: state IDLE, owner=0, last=1 (m0 wins first tie), locked=0, count=0.
//   All outputs at reset: db_accessType=NONE, mN_ready=0, mN_err=0, busy=0, grant=0.
//  States: IDLE, BUSY. reqN = (mN_accessType != `MEM_ACCESS_NONE).
//  IDLE: db_accessType=NONE, other db_* outputs driven from m0 (don't-care).
//   If locked: only the owner is eligible; go BUSY when owner requests.
//   Else if reqN exactly one: owner<=that N. If both: owner<=~last. Go BUSY.
//   Grant latency: request seen in IDLE cycle t -> downstream access from cycle t+1.
//  BUSY: db_* = owner's live mN_* inputs (combinational mux). Requester holds stable.
//   count increments each BUSY cycle; cleared on entering BUSY.
//   db_ready=1: m<owner>_ready=1 same cycle, last<=owner, locked<=m<owner>_lock,
//    state<=IDLE. Non-owner ready is never asserted.
//   Owner drops accessType to NONE (abort, e.g. MMU exception): state<=IDLE,
//    no ready, locked<=0, db_accessType=NONE that cycle.
//   TIMEOUT!=0 and count==TIMEOUT-1 and no db_ready: m<owner>_ready=1, m<owner>_err=1,
//    db_accessType forced NONE that cycle, locked<=0, last<=owner, state<=IDLE.
//   db_ready and timeout in same cycle: db_ready wins, err=0.
//   db_ready and owner abort in same cycle: abort wins (owner not requesting).
//  Minimum one IDLE cycle between transfers; no back-to-back grant.
//  Lock: while locked, the other requester is starved until owner completes with lock=0
//   or aborts. Lock is sampled only at normal completion.
//  db_ready in IDLE is ignored. res mid-transfer: immediate return to reset values,
//   no ready strobe issued.
//  count width CNT_W; saturates at all-ones if TIMEOUT=0 (no wrap-around effect).
// TESTING
//  1 m0 R to 0x100, db_ready after 3 cycles -> db_accessType=R cycles 1-3, m0_ready=1 on
//    cycle 3 with m0_dataIn=db_dataIn, busy=0 next cycle.
//  2 m0 and m1 request together, repeat twice -> grants m0,m1,m0,m1 (round-robin).
//  3 m1 W with m1_lock=1, m0 requesting throughout -> m1 wins two consecutive
//    transfers; m0 granted only after m1 completes with lock=0.
//  4 TIMEOUT=4, m0 R, db_ready never -> m0_ready=m0_err=1 on 4th BUSY cycle, db_accessType
//    NONE that cycle, then IDLE.
//  5 m0 X granted, m0_accessType->NONE before db_ready -> IDLE, no m0_ready, m1 then
//    granted if requesting.
//  6 res asserted mid-BUSY -> all outputs at reset values asynchronously; m0 wins next tie.

Source files
------------

// File: rtl/db_arbiter.sv
// Two-requester round-robin arbiter for the shared data bus; holds the grant for a
// whole transfer and completes it on db_ready, owner abort, or timeout.
module db_arbiter #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned ACC_W   = 2,
  parameter int unsigned LEN_W   = 2,
  parameter logic [ACC_W-1:0] ACC_NONE = '0
) (
  input  logic             clk,
  input  logic             res,
  input  logic [31:0]      m0_addr,
  input  logic [31:0]      m0_dataOut,
  input  logic [ACC_W-1:0] m0_accessType,
  input  logic [LEN_W-1:0] m0_memLen,
  input  logic             m0_io,
  input  logic             m0_lock,
  output logic [31:0]      m0_dataIn,
  output logic             m0_ready,
  output logic             m0_err,
  input  logic [31:0]      m1_addr,
  input  logic [31:0]      m1_dataOut,
  input  logic [ACC_W-1:0] m1_accessType,
  input  logic [LEN_W-1:0] m1_memLen,
  input  logic             m1_io,
  input  logic             m1_lock,
  output logic [31:0]      m1_dataIn,
  output logic             m1_ready,
  output logic             m1_err,
  output logic [31:0]      db_addr,
  output logic [31:0]      db_dataOut,
  output logic [ACC_W-1:0] db_accessType,
  output logic [LEN_W-1:0] db_memLen,
  output logic             db_io,
  input  logic [31:0]      db_dataIn,
  input  logic             db_ready,
  output logic             grant,
  output logic             busy
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic             locked_q, locked_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic req0, req1, own_req, own_lock, timeout_hit;
  logic done_ok, done_to, abort;

  assign req0        = (m0_accessType != ACC_NONE);
  assign req1        = (m1_accessType != ACC_NONE);
  assign own_req     = owner_q ? req1 : req0;
  assign own_lock    = owner_q ? m1_lock : m0_lock;
  assign timeout_hit = (TIMEOUT != 0) && (count_q == TO_LAST);
  // db_ready beats timeout; an owner that stopped requesting beats both
  assign abort   = (state_q == BUSY) && !own_req;
  assign done_ok = (state_q == BUSY) && own_req && db_ready;
  assign done_to = (state_q == BUSY) && own_req && !db_ready && timeout_hit;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      locked_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      locked_q <= locked_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    locked_d = locked_q;
    count_d  = count_q;
    case (state_q)
      IDLE: begin
        if (locked_q) begin
          if (own_req) begin
            state_d = BUSY;
            count_d = '0;
          end
        end else if (req0 || req1) begin
          state_d = BUSY;
          count_d = '0;
          owner_d = (req0 && req1) ? ~last_q : req1;
        end
      end
      BUSY: begin
        if (abort) begin
          state_d  = IDLE;
          locked_d = 1'b0;
        end else if (done_ok) begin
          state_d  = IDLE;
          last_d   = owner_q;
          locked_d = own_lock;
        end else if (done_to) begin
          state_d  = IDLE;
          last_d   = owner_q;
          locked_d = 1'b0;
        end else if (count_q != '1) begin
          count_d = count_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Downstream mux follows the owner's live inputs; idle drives m0 with NONE access
  always_comb begin
    db_addr       = m0_addr;
    db_dataOut    = m0_dataOut;
    db_memLen     = m0_memLen;
    db_io         = m0_io;
    db_accessType = ACC_NONE;
    m0_ready      = 1'b0;
    m1_ready      = 1'b0;
    m0_err        = 1'b0;
    m1_err        = 1'b0;
    if (state_q == BUSY) begin
      db_addr    = owner_q ? m1_addr    : m0_addr;
      db_dataOut = owner_q ? m1_dataOut : m0_dataOut;
      db_memLen  = owner_q ? m1_memLen  : m0_memLen;
      db_io      = owner_q ? m1_io      : m0_io;
      if (own_req && !done_to) begin
        db_accessType = owner_q ? m1_accessType : m0_accessType;
      end
      m0_ready = !owner_q && (done_ok || done_to);
      m1_ready =  owner_q && (done_ok || done_to);
      m0_err   = !owner_q && done_to;
      m1_err   =  owner_q && done_to;
    end
  end

  assign busy      = (state_q == BUSY);
  assign grant     = owner_q;
  assign m0_dataIn = db_dataIn;
  assign m1_dataIn = db_dataIn;

endmodule

// File: tb/tb_db_arbiter.sv
// Bench for db_arbiter: directed vector table, reset sequence, and random traffic
// against a transaction-level reference model.
module tb_db_arbiter;
  localparam int unsigned TO = 4;
  localparam logic [1:0] A_N = 2'd0, A_R = 2'd1, A_W = 2'd2, A_X = 2'd3;

  logic        clk = 1'b0;
  logic        res;
  logic [31:0] m_addr[2];
  logic [31:0] m_dout[2];
  logic [1:0]  m_acc[2];
  logic [1:0]  m_len[2];
  logic        m_io[2];
  logic        m_lock[2];
  logic [31:0] m0_dataIn, m1_dataIn, db_addr, db_dataOut, db_dataIn;
  logic        m0_ready, m1_ready, m0_err, m1_err, db_io, db_ready, grant, busy;
  logic [1:0]  db_accessType, db_memLen;

  int total = 0;
  int bad   = 0;

  db_arbiter #(.TIMEOUT(TO), .CNT_W(8), .ACC_W(2), .LEN_W(2), .ACC_NONE(2'd0)) dut (
    .clk(clk), .res(res),
    .m0_addr(m_addr[0]), .m0_dataOut(m_dout[0]), .m0_accessType(m_acc[0]),
    .m0_memLen(m_len[0]), .m0_io(m_io[0]), .m0_lock(m_lock[0]),
    .m0_dataIn(m0_dataIn), .m0_ready(m0_ready), .m0_err(m0_err),
    .m1_addr(m_addr[1]), .m1_dataOut(m_dout[1]), .m1_accessType(m_acc[1]),
    .m1_memLen(m_len[1]), .m1_io(m_io[1]), .m1_lock(m_lock[1]),
    .m1_dataIn(m1_dataIn), .m1_ready(m1_ready), .m1_err(m1_err),
    .db_addr(db_addr), .db_dataOut(db_dataOut), .db_accessType(db_accessType),
    .db_memLen(db_memLen), .db_io(db_io), .db_dataIn(db_dataIn), .db_ready(db_ready),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] a0, a1;
    logic       l0, l1, rdy;
    logic       e_busy, e_grant;
    logic [1:0] e_acc;
    logic       e_r0, e_r1, e_err;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [1:0] a0, a1, input logic l0, l1, rdy, eb, eg,
                     input logic [1:0] ea, input logic er0, er1, ee);
    tbl.push_back(vec_t'{a0, a1, l0, l1, rdy, eb, eg, ea, er0, er1, ee});
  endtask

  // Reference model: one outstanding transfer described by who owns it and its age
  logic mb, mo, ml, mlk;
  int   mage;
  logic [1:0] e_acc;
  logic e_rdy[2];
  logic e_err;

  task automatic model_eval();
    e_acc = A_N; e_rdy[0] = 1'b0; e_rdy[1] = 1'b0; e_err = 1'b0;
    if (mb) begin
      if (m_acc[mo] == A_N) begin
        e_acc = A_N;
      end else if (db_ready) begin
        e_acc = m_acc[mo]; e_rdy[mo] = 1'b1;
      end else if (mage + 1 == int'(TO)) begin
        e_rdy[mo] = 1'b1; e_err = 1'b1;
      end else begin
        e_acc = m_acc[mo];
      end
    end
  endtask

  task automatic model_step();
    logic w0, w1;
    w0 = (m_acc[0] != A_N);
    w1 = (m_acc[1] != A_N);
    if (!mb) begin
      if (mlk) begin
        if (m_acc[mo] != A_N) begin mb = 1'b1; mage = 0; end
      end else if (w0 || w1) begin
        mb = 1'b1; mage = 0;
        mo = (w0 && w1) ? !ml : w1;
      end
    end else if (m_acc[mo] == A_N) begin
      mb = 1'b0; mlk = 1'b0;
    end else if (e_rdy[mo]) begin
      mb = 1'b0; ml = mo; mlk = e_err ? 1'b0 : m_lock[mo];
    end else begin
      mage++;
    end
  endtask

  task automatic set_idle_inputs();
    for (int n = 0; n < 2; n++) begin
      m_acc[n] = A_N; m_lock[n] = 1'b0; m_len[n] = 2'd0; m_io[n] = 1'b0;
    end
    m_addr[0] = 32'h100; m_addr[1] = 32'h200;
    m_dout[0] = 32'hAAAA_0000; m_dout[1] = 32'hBBBB_1111;
    db_ready = 1'b0; db_dataIn = 32'h0;
  endtask

  logic act[2];
  logic prev_rdy[2];

  initial begin
    res = 1'b1;
    set_idle_inputs();
    #2;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset grant", 32'(grant), 32'd0);
    chk("reset acc", 32'(db_accessType), 32'd0);
    chk("reset r0", 32'(m0_ready), 32'd0);
    chk("reset r1", 32'(m1_ready), 32'd0);
    chk("reset err", 32'({m0_err, m1_err}), 32'd0);
    @(negedge clk); @(negedge clk);
    res = 1'b0;

    // round robin
    add(A_R, A_W, 0, 0, 0, 0, 0, A_N, 0, 0, 0);
    add(A_R, A_W, 0, 0, 1, 1, 0, A_R, 1, 0, 0);
    add(A_R, A_W, 0, 0, 0, 0, 0, A_N, 0, 0, 0);
    add(A_R, A_W, 0, 0, 1, 1, 1, A_W, 0, 1, 0);
    add(A_R, A_W, 0, 0, 0, 0, 0, A_N, 0, 0, 0);
    add(A_R, A_W, 0, 0, 1, 1, 0, A_R, 1, 0, 0);
    add(A_R, A_W, 0, 0, 0, 0, 0, A_N, 0, 0, 0);
    add(A_R, A_W, 0, 0, 1, 1, 1, A_W, 0, 1, 0);
    add(A_N, A_N, 0, 0, 0, 0, 0, A_N, 0, 0, 0);
    // single read, ready on third busy cycle
    add(A_R, A_N, 0, 0, 0, 0, 0, A_N, 0, 0, 0);
    add(A_R, A_N, 0, 0, 0, 1, 0, A_R, 0, 0, 0);
    add(A_R, A_N, 0, 0, 0, 1, 0, A_R, 0, 0, 0);
    add(A_R, A_N, 0, 0, 1, 1, 0, A_R, 1, 0, 0);
    add(A_N, A_N, 0, 0, 0, 0, 0, A_N, 0, 0, 0);
    // lock keeps m1 ahead of m0
    add(A_R, A_W, 0, 1, 0, 0, 0, A_N, 0, 0, 0);
    add(A_R, A_W, 0, 1, 1, 1, 1, A_W, 0, 1, 0);
    add(A_R, A_W, 0, 1, 0, 0, 0, A_N, 0, 0, 0);
    add(A_R, A_W, 0, 0, 1, 1, 1, A_W, 0, 1, 0);
    add(A_R, A_W, 0, 0, 0, 0, 0, A_N, 0, 0, 0);
    add(A_R, A_W, 0, 0, 1, 1, 0, A_R, 1, 0, 0);
    add(A_N, A_N, 0, 0, 0, 0, 0, A_N, 0, 0, 0);
    // timeout on 4th busy cycle
    add(A_R, A_N, 0, 0, 0, 0, 0, A_N, 0, 0, 0);
    add(A_R, A_N, 0, 0, 0, 1, 0, A_R, 0, 0, 0);
    add(A_R, A_N, 0, 0, 0, 1, 0, A_R, 0, 0, 0);
    add(A_R, A_N, 0, 0, 0, 1, 0, A_R, 0, 0, 0);
    add(A_R, A_N, 0, 0, 0, 1, 0, A_N, 1, 0, 1);
    add(A_N, A_N, 0, 0, 0, 0, 0, A_N, 0, 0, 0);
    // ready coinciding with timeout
    add(A_R, A_N, 0, 0, 0, 0, 0, A_N, 0, 0, 0);
    add(A_R, A_N, 0, 0, 0, 1, 0, A_R, 0, 0, 0);
    add(A_R, A_N, 0, 0, 0, 1, 0, A_R, 0, 0, 0);
    add(A_R, A_N, 0, 0, 0, 1, 0, A_R, 0, 0, 0);
    add(A_R, A_N, 0, 0, 1, 1, 0, A_R, 1, 0, 0);
    add(A_N, A_N, 0, 0, 0, 0, 0, A_N, 0, 0, 0);
    // abort beats ready, then m1 granted; ready in idle ignored
    add(A_X, A_N, 0, 0, 0, 0, 0, A_N, 0, 0, 0);
    add(A_X, A_N, 0, 0, 0, 1, 0, A_X, 0, 0, 0);
    add(A_N, A_W, 0, 0, 1, 1, 0, A_N, 0, 0, 0);
    add(A_N, A_W, 0, 0, 0, 0, 0, A_N, 0, 0, 0);
    add(A_N, A_W, 0, 0, 1, 1, 1, A_W, 0, 1, 0);
    add(A_N, A_N, 0, 0, 1, 0, 0, A_N, 0, 0, 0);
    add(A_N, A_N, 0, 0, 0, 0, 0, A_N, 0, 0, 0);
    // lock starves m0 until the lock owner aborts
    add(A_N, A_W, 0, 1, 0, 0, 0, A_N, 0, 0, 0);
    add(A_N, A_W, 0, 1, 1, 1, 1, A_W, 0, 1, 0);
    add(A_R, A_N, 0, 0, 0, 0, 0, A_N, 0, 0, 0);
    add(A_R, A_N, 0, 0, 0, 0, 0, A_N, 0, 0, 0);
    add(A_R, A_W, 0, 0, 0, 0, 0, A_N, 0, 0, 0);
    add(A_R, A_N, 0, 0, 0, 1, 1, A_N, 0, 0, 0);
    add(A_R, A_N, 0, 0, 0, 0, 0, A_N, 0, 0, 0);
    add(A_R, A_N, 0, 0, 1, 1, 0, A_R, 1, 0, 0);
    add(A_N, A_N, 0, 0, 0, 0, 0, A_N, 0, 0, 0);

    foreach (tbl[i]) begin
      @(negedge clk);
      m_acc[0] = tbl[i].a0; m_acc[1] = tbl[i].a1;
      m_lock[0] = tbl[i].l0; m_lock[1] = tbl[i].l1;
      db_ready = tbl[i].rdy;
      db_dataIn = 32'h5000 + 32'(i);
      #1;
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("v%0d acc", i), 32'(db_accessType), 32'(tbl[i].e_acc));
      chk($sformatf("v%0d r0", i), 32'(m0_ready), 32'(tbl[i].e_r0));
      chk($sformatf("v%0d r1", i), 32'(m1_ready), 32'(tbl[i].e_r1));
      chk($sformatf("v%0d err0", i), 32'(m0_err), 32'(tbl[i].e_err && tbl[i].e_r0));
      chk($sformatf("v%0d err1", i), 32'(m1_err), 32'(tbl[i].e_err && tbl[i].e_r1));
      if (tbl[i].e_busy) begin
        chk($sformatf("v%0d grant", i), 32'(grant), 32'(tbl[i].e_grant));
        chk($sformatf("v%0d addr", i), db_addr, tbl[i].e_grant ? 32'h200 : 32'h100);
      end
      if (tbl[i].e_r0) chk($sformatf("v%0d din0", i), m0_dataIn, 32'h5000 + 32'(i));
    end

    // asynchronous reset mid-transfer (last owner was m0), then m0 wins the tie
    @(negedge clk);
    m_acc[0] = A_R; m_acc[1] = A_N; db_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("pre-reset busy", 32'(busy), 32'd1);
    #2;
    res = 1'b1;
    #1;
    chk("async reset busy", 32'(busy), 32'd0);
    chk("async reset acc", 32'(db_accessType), 32'd0);
    chk("async reset r0", 32'(m0_ready), 32'd0);
    chk("async reset grant", 32'(grant), 32'd0);
    @(negedge clk);
    res = 1'b0; m_acc[0] = A_R; m_acc[1] = A_W;
    @(negedge clk);
    #1;
    chk("post-reset busy", 32'(busy), 32'd1);
    chk("post-reset tie grant", 32'(grant), 32'd0);

    // random traffic against the model
    @(negedge clk);
    res = 1'b1;
    set_idle_inputs();
    @(negedge clk);
    res = 1'b0;
    mb = 1'b0; mo = 1'b0; ml = 1'b1; mlk = 1'b0; mage = 0;
    act[0] = 1'b0; act[1] = 1'b0; prev_rdy[0] = 1'b0; prev_rdy[1] = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int n = 0; n < 2; n++) begin
        if (act[n] && (prev_rdy[n] || ($urandom % 25 == 0))) begin
          act[n] = 1'b0;
        end else if (!act[n] && ($urandom % 3 == 0)) begin
          act[n] = 1'b1;
          m_acc[n]  = 2'($urandom_range(1, 3));
          m_addr[n] = $urandom;
          m_dout[n] = $urandom;
          m_len[n]  = 2'($urandom);
          m_io[n]   = 1'($urandom);
          m_lock[n] = ($urandom % 4 == 0);
        end
        if (!act[n]) m_acc[n] = A_N;
      end
      db_ready  = ($urandom % 4 == 0);
      db_dataIn = $urandom;
      #1;
      model_eval();
      chk("rnd busy", 32'(busy), 32'(mb));
      chk("rnd acc", 32'(db_accessType), 32'(e_acc));
      chk("rnd r0", 32'(m0_ready), 32'(e_rdy[0]));
      chk("rnd r1", 32'(m1_ready), 32'(e_rdy[1]));
      chk("rnd err0", 32'(m0_err), 32'(e_err && e_rdy[0]));
      chk("rnd err1", 32'(m1_err), 32'(e_err && e_rdy[1]));
      chk("rnd din1", m1_dataIn, db_dataIn);
      if (mb) begin
        chk("rnd grant", 32'(grant), 32'(mo));
        if (m_acc[mo] != A_N) begin
          chk("rnd addr", db_addr, m_addr[mo]);
          chk("rnd dout", db_dataOut, m_dout[mo]);
          chk("rnd len", 32'(db_memLen), 32'(m_len[mo]));
          chk("rnd io", 32'(db_io), 32'(m_io[mo]));
        end
      end
      prev_rdy[0] = e_rdy[0];
      prev_rdy[1] = e_rdy[1];
      model_step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
